// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store unit.
//   - RV32I funct3 width/sign codes (F3_*)
//   - FSM state encoding (S_*), 3 bits, legacy-compatible localparams
//   - f3_illegal(): rejects funct3 codes that have no meaning for the
//     given direction (load or store)
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LD     = 3'd1;
  localparam logic [2:0] S_ST     = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // Unsigned variants exist only for loads; 011/110/111 never exist.
  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = write;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
//   word     in  32  word read from memory
//   wdata    in  32  right-aligned store data
//   addr_lo  in  2   byte offset within the word
//   funct3   in  3   width/sign code
//   load_val out 32  extracted and sign/zero-extended load result
//   merged   out 32  word with the store lane(s) replaced by wdata
// Halfword lane is chosen by addr_lo[1] only; addr_lo[0] plays no part.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_val = word;
    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'd0, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'd0, half_sel};
      default: load_val = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage initiator for a word-addressed data memory.
// Loads are a single read; SW is a single write; SB/SH are read-modify-write
// because the memory only writes full words.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : request
//   resp_valid/resp_rdata/resp_err                              : response
//   mem_addr/mem_din/mem_read/mem_write/mem_dout                : memory
//   dbg_state : current FSM state (lsu_pkg S_* encoding)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so req_valid is
// ignored while busy and requests need not be withdrawn. resp_valid is a
// single-cycle pulse with no back-pressure; resp_err qualifies it.
//
// Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses; otherwise the low address bits are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [2:0]        dbg_state
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] din_q;

  logic [31:0] load_val;
  logic [31:0] merged;
  logic        accept;
  logic        misalign;
  logic        reject;

  assign accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
  // funct3[1:0]==01 covers both halfword codes (LH/SH and LHU).
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject = f3_illegal(req_write, req_funct3) || misalign;

  // Memory read data is combinational, so the aligner works straight off
  // mem_dout; the result is registered in LD (load value) or RMW_RD (merged
  // word), which keeps the write cycle free of the memory read path.
  lsu_align u_align (
    .word     (mem_dout),
    .wdata    (wdata_q),
    .addr_lo  (addr_q[1:0]),
    .funct3   (f3_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      din_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            f3_q    <= req_funct3;
            write_q <= req_write;
            wdata_q <= req_wdata;
            if (reject)                 state <= S_ERR;
            else if (!req_write)        state <= S_LD;
            else if (req_funct3 == F3_W) state <= S_ST;
            else                        state <= S_RMW_RD;
          end
        end
        S_LD: begin
          rdata_q <= load_val;
          state   <= S_RESP;
        end
        S_ST:     state <= S_RESP;
        S_RMW_RD: begin
          din_q <= merged;
          state <= S_RMW_WR;
        end
        S_RMW_WR: state <= S_RESP;
        S_RESP:   state <= S_IDLE;
        S_ERR:    state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from state only.
  assign req_ready  = (state == S_IDLE);
  assign mem_read   = (state == S_LD) || (state == S_RMW_RD);
  assign mem_write  = (state == S_ST) || (state == S_RMW_WR);
  assign resp_valid = (state == S_RESP) || (state == S_ERR);
  assign resp_err   = (state == S_ERR);
  assign resp_rdata = ((state == S_RESP) && !write_q) ? rdata_q : '0;
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_din    = (state == S_ST)     ? wdata_q :
                      (state == S_RMW_WR) ? din_q   : '0;
  assign dbg_state  = state;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage initiator for the word-addressed data memory.
- Takes one load or store per request from the pipeline and drives the memory's address, write data, read enable and write enable.
- Performs byte/halfword extraction with sign or zero extension on loads.
- Builds byte/halfword stores as read-modify-write sequences, because the memory supports only full-word writes.
- Holds off the pipeline through req_ready while an access is in flight.

Parameters:
ADDR_W, 32, width of the byte address
DATA_W, 32, data width; fixed at 32

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  pipeline presents a memory request
req_ready  out  1  unit can accept a request; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width/sign code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_err  out  1  qualifies resp_valid; request rejected, no memory access made
mem_addr  out  32  word-aligned address {addr_q[31:2],2'b00}
mem_din  out  32  word written to memory
mem_read  out  1  memory read enable; memory read data is combinational
mem_write  out  1  memory write enable; memory commits the word on the rising clock edge
mem_dout  in  32  memory read data, valid in the same cycle as mem_read

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; all internal registers cleared.
  - req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_read=0; mem_write=0; mem_addr=0; mem_din=0.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready (cycle T).
  - addr, funct3, write and wdata are registered at acceptance.
  - req_ready=0 from T+1 until the unit returns to IDLE.
- States:
  - IDLE
    - accept → ERR if the request is rejected (see error rules)
    - load → LD
    - SW → ST
    - SB/SH → RMW_RD
  - LD: mem_read=1; mem_dout captured at edge end of T+1 → RESP.
  - ST: mem_write=1; mem_din=wdata → RESP.
  - RMW_RD: mem_read=1; mem_dout captured as old word → RMW_WR.
  - RMW_WR: mem_write=1; mem_din=merge(old word, wdata, addr[1:0], size) → RESP.
  - RESP: resp_valid=1 → IDLE.
  - ERR: resp_valid=1, resp_err=1 → IDLE.
- Latency (resp_valid cycle):
  - load and SW: T+2
  - SB/SH: T+3
  - error: T+1
  - Next accept is possible in the cycle after resp_valid.
- Output timing: mem_read, mem_write and resp_valid are Moore outputs decoded from state only. mem_read and mem_write are never high together.
- Load extraction: byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store merge:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces lane addr[1] with wdata[15:0].
  - Other bytes keep the read value.
- Error rules:
  - funct3 011, 110 or 111 is always an error.
  - Store funct3 100 or 101 is always an error.
  - Misalignment errors are covered under Optional Feature.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_write drops at once.
  - In RMW_RD, memory stays unchanged.
  - No resp_valid is generated for the aborted request.
- req_valid is ignored while req_ready=0.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: these requests take the ERR path and make no memory access.
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]≠0
- Undefined: these low address bits are silently ignored and resp_err is raised only for illegal funct3.
  - halfword: addr[0] ignored
  - word: addr[1:0] ignored

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state encoding S_IDLE, S_LD, S_ST, S_RMW_RD, S_RMW_WR, S_RESP, S_ERR
- Sub-module lsu_align (purely combinational) contains load extract/extend and store merge.
  - Inputs: word, wdata, addr[1:0], funct3.
  - Outputs: load value and merged word.
  - The FSM stays in load_store_unit.

Test Plan:
- Mem[0x100]=0x8899AABB; LB at 0x101 → resp_rdata=0xFFFFFFAA at T+2; LBU at 0x103 → 0x00000088.
- SB at 0x102, wdata=0x12 → one read cycle, then write of 0x8812AABB at T+2; resp_valid at T+3; a following LW at 0x100 → 0x8812AABB.
- SW at 0x200, wdata=0xDEADBEEF, then LH at 0x202 → 0xFFFFDEAD; LHU at 0x200 → 0x0000BEEF.
- LH at 0x101:
  - with macro → resp_err=1 at T+1, mem_read never asserted;
  - without macro → 0xFFFFAABB.
- Assert reset low during RMW_RD of SB at 0x100 → req_ready=1 immediately, mem_write never pulses, memory unchanged, no resp_valid.
- req_funct3=011 with req_write=0 → resp_err=1 at T+1; req_valid held high while busy → exactly one accept per response.
